imem_program_loader: RTL and testbench

//  Write-side companion to the instruction memory. Receives a framed byte stream
//  (host/UART side) and issues byte writes into IMem, little-endian, from BASE_ADDR.

---
 rtl/imem_program_loader.sv | 178 +++++++++++++++++
 tb/tb_imem_program_loader.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/imem_program_loader.sv
// Instruction-memory program loader.
// Accepts a framed byte stream (SYNC, LEN_LO, LEN_HI, 4*N payload bytes, XOR checksum)
// and writes the payload bytes little-endian into IMem starting at BASE_ADDR. The CPU
// pipeline is held until a complete image with a good checksum has been loaded.
// Ports:
//   clk, reset              clock (rising edge), asynchronous active-high reset
//   Byte_In/Valid/Ready     incoming byte stream handshake
//   Clear                   one-cycle pulse returning DONE/ERROR to IDLE
//   Wr_En/Address/Data      IMem byte write port (registered)
//   Done, Error             level status, mutually exclusive (registered)
//   Cpu_Hold                pipeline hold, low only in DONE (registered)
module imem_program_loader #(
    parameter logic [63:0] BASE_ADDR = 64'd0,
    parameter int unsigned MAX_WORDS = 4,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  Byte_In,
    input  logic        Byte_Valid,
    output logic        Byte_Ready,
    input  logic        Clear,
    output logic        Wr_En,
    output logic [63:0] Wr_Address,
    output logic [7:0]  Wr_Data,
    output logic        Done,
    output logic        Error,
    output logic        Cpu_Hold
);

    // Byte counter must hold 4*MAX_WORDS (value after the last payload byte).
    localparam int unsigned CNT_W = $clog2(4 * MAX_WORDS) + 1;
    localparam int unsigned LEN_W = 16;
    localparam int unsigned TOT_W = LEN_W + 2;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN0  = 3'd1,
        S_LEN1  = 3'd2,
        S_DATA  = 3'd3,
        S_CHECK = 3'd4,
        S_DONE  = 3'd5,
        S_ERROR = 3'd6
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         len_lo_q, len_lo_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         acc_q, acc_d;
    logic               wr_en_q, wr_en_d;
    logic [63:0]        wr_addr_q, wr_addr_d;
    logic [7:0]         wr_data_q, wr_data_d;
    logic               done_q, done_d;
    logic               error_q, error_d;
    logic               hold_q, hold_d;
    logic               ready_q, ready_d;

    logic               xfer_c;
    logic [LEN_W-1:0]   len_full_c;
    logic               last_byte_c;

    assign xfer_c      = Byte_Valid & ready_q;
    assign len_full_c  = {Byte_In, len_lo_q};
    // Index of the final payload byte is 4*N-1; only evaluated in DATA where N >= 1.
    assign last_byte_c = (TOT_W'(cnt_q) == (TOT_W'({len_q, 2'b00}) - TOT_W'(1)));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (xfer_c && (Byte_In == SYNC_BYTE)) state_d = S_LEN0;
            S_LEN0:  if (xfer_c) state_d = S_LEN1;
            S_LEN1: begin
                if (xfer_c) begin
                    if (len_full_c > LEN_W'(MAX_WORDS)) state_d = S_ERROR;
                    else if (len_full_c == '0)          state_d = S_CHECK;
                    else                                state_d = S_DATA;
                end
            end
            S_DATA:  if (xfer_c && last_byte_c) state_d = S_CHECK;
            S_CHECK: if (xfer_c) state_d = (Byte_In == acc_q) ? S_DONE : S_ERROR;
            S_DONE,
            S_ERROR: if (Clear) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and output next values
    always_comb begin
        len_lo_d  = len_lo_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        case (state_q)
            S_IDLE: begin
                if (xfer_c && (Byte_In == SYNC_BYTE)) begin
                    cnt_d = '0;
                    acc_d = '0;
                end
            end
            S_LEN0:  if (xfer_c) len_lo_d = Byte_In;
            S_LEN1:  if (xfer_c) len_d = len_full_c;
            S_DATA: begin
                if (xfer_c) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = BASE_ADDR + 64'(cnt_q);
                    wr_data_d = Byte_In;
                    acc_d     = acc_q ^ Byte_In;
                    cnt_d     = cnt_q + CNT_W'(1);
                end
            end
            S_DONE,
            S_ERROR: begin
                if (Clear) begin
                    cnt_d = '0;
                    acc_d = '0;
                end
            end
            default: ;
        endcase
        // Status flags track the state being entered so they change with it.
        done_d  = (state_d == S_DONE);
        error_d = (state_d == S_ERROR);
        hold_d  = (state_d != S_DONE);
        ready_d = (state_d != S_DONE) && (state_d != S_ERROR);
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_lo_q  <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            acc_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            hold_q    <= 1'b1;
            ready_q   <= 1'b1;
        end else begin
            len_lo_q  <= len_lo_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
            error_q   <= error_d;
            hold_q    <= hold_d;
            ready_q   <= ready_d;
        end
    end

    assign Byte_Ready = ready_q;
    assign Wr_En      = wr_en_q;
    assign Wr_Address = wr_addr_q;
    assign Wr_Data    = wr_data_q;
    assign Done       = done_q;
    assign Error      = error_q;
    assign Cpu_Hold   = hold_q;

endmodule

// File: tb/tb_imem_program_loader.sv
// Directed testbench for imem_program_loader.
module tb_imem_program_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  Byte_In;
    logic        Byte_Valid;
    logic        Byte_Ready;
    logic        Clear;
    logic        Wr_En;
    logic [63:0] Wr_Address;
    logic [7:0]  Wr_Data;
    logic        Done;
    logic        Error;
    logic        Cpu_Hold;

    int n_vec = 0;
    int n_err = 0;

    // Write log filled by the monitor
    logic [63:0] log_addr [64];
    logic [7:0]  log_data [64];
    int          wr_cnt   = 0;
    int          hold_viol = 0;
    logic        prev_en   = 1'b0;
    logic [63:0] prev_addr = '0;

    int base;
    logic [7:0] frame1 [8];

    imem_program_loader dut (
        .clk        (clk),
        .reset      (reset),
        .Byte_In    (Byte_In),
        .Byte_Valid (Byte_Valid),
        .Byte_Ready (Byte_Ready),
        .Clear      (Clear),
        .Wr_En      (Wr_En),
        .Wr_Address (Wr_Address),
        .Wr_Data    (Wr_Data),
        .Done       (Done),
        .Error      (Error),
        .Cpu_Hold   (Cpu_Hold)
    );

    always #5 clk = ~clk;

    // Capture every write strobe; a strobe held on the same address twice is a violation.
    always @(negedge clk) begin
        if (Wr_En) begin
            if (wr_cnt < 64) begin
                log_addr[wr_cnt] = Wr_Address;
                log_data[wr_cnt] = Wr_Data;
            end
            wr_cnt = wr_cnt + 1;
            if (prev_en && (prev_addr == Wr_Address)) hold_viol = hold_viol + 1;
        end
        prev_en   = Wr_En;
        prev_addr = Wr_Address;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        Byte_In    = b;
        Byte_Valid = 1'b1;
        @(posedge clk);
        #1;
        Byte_Valid = 1'b0;
    endtask

    task automatic bubbles(input int n);
        Byte_Valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        Clear = 1'b1;
        @(posedge clk);
        #1;
        Clear = 1'b0;
    endtask

    // Check the four test-1 writes logged from index b onwards
    task automatic chk_writes(input string tag, input int b);
        logic [7:0] exp_d [4];
        exp_d[0] = 8'h93; exp_d[1] = 8'h02; exp_d[2] = 8'h40; exp_d[3] = 8'h00;
        chk({tag, "_wrcnt"}, 64'(wr_cnt - b), 64'd4);
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_addr"}, log_addr[b + i], 64'(i));
            chk({tag, "_data"}, 64'(log_data[b + i]), 64'(exp_d[i]));
        end
    endtask

    initial begin
        frame1[0] = 8'hA5; frame1[1] = 8'h01; frame1[2] = 8'h00; frame1[3] = 8'h93;
        frame1[4] = 8'h02; frame1[5] = 8'h40; frame1[6] = 8'h00; frame1[7] = 8'hD1;

        reset = 1'b1; Byte_In = '0; Byte_Valid = 1'b0; Clear = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_done",  64'(Done), 64'd0);
        chk("rst_error", 64'(Error), 64'd0);
        chk("rst_hold",  64'(Cpu_Hold), 64'd1);
        chk("rst_ready", 64'(Byte_Ready), 64'd1);
        chk("rst_wren",  64'(Wr_En), 64'd0);
        chk("rst_waddr", Wr_Address, 64'd0);
        chk("rst_wdata", 64'(Wr_Data), 64'd0);
        reset = 1'b0;
        bubbles(1);

        // Test 1: good single-word image
        base = wr_cnt;
        for (int i = 0; i < 7; i++) send_byte(frame1[i]);
        chk("t1_pre_done", 64'(Done), 64'd0);
        chk("t1_pre_hold", 64'(Cpu_Hold), 64'd1);
        send_byte(frame1[7]);
        chk("t1_done",  64'(Done), 64'd1);
        chk("t1_hold",  64'(Cpu_Hold), 64'd0);
        chk("t1_error", 64'(Error), 64'd0);
        chk("t1_ready", 64'(Byte_Ready), 64'd0);
        chk_writes("t1", base);
        pulse_clear();
        chk("t1_clr_done",  64'(Done), 64'd0);
        chk("t1_clr_hold",  64'(Cpu_Hold), 64'd1);
        chk("t1_clr_ready", 64'(Byte_Ready), 64'd1);

        // Test 2: bad checksum
        base = wr_cnt;
        for (int i = 0; i < 7; i++) send_byte(frame1[i]);
        send_byte(8'hD0);
        chk_writes("t2", base);
        chk("t2_error", 64'(Error), 64'd1);
        chk("t2_done",  64'(Done), 64'd0);
        chk("t2_hold",  64'(Cpu_Hold), 64'd1);
        chk("t2_ready", 64'(Byte_Ready), 64'd0);
        pulse_clear();
        chk("t2_clr_error", 64'(Error), 64'd0);
        chk("t2_clr_ready", 64'(Byte_Ready), 64'd1);

        // Test 3: oversized length
        base = wr_cnt;
        send_byte(8'hA5); send_byte(8'h05); send_byte(8'h00);
        bubbles(2);
        chk("t3_error", 64'(Error), 64'd1);
        chk("t3_done",  64'(Done), 64'd0);
        chk("t3_wrcnt", 64'(wr_cnt - base), 64'd0);
        pulse_clear();

        // Test 4: leading garbage, empty image
        base = wr_cnt;
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'h13);
        chk("t4_idle_done", 64'(Done), 64'd0);
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        bubbles(1);
        chk("t4_done",  64'(Done), 64'd1);
        chk("t4_error", 64'(Error), 64'd0);
        chk("t4_wrcnt", 64'(wr_cnt - base), 64'd0);
        pulse_clear();

        // Test 5: bubbles between bytes
        base = wr_cnt;
        for (int i = 0; i < 8; i++) begin
            send_byte(frame1[i]);
            bubbles(3);
        end
        chk_writes("t5", base);
        chk("t5_done",  64'(Done), 64'd1);
        chk("t5_hold",  64'(Cpu_Hold), 64'd0);
        chk("t5_wr_held", 64'(hold_viol), 64'd0);
        pulse_clear();

        // Test 6: reset mid-DATA, then full frame
        for (int i = 0; i < 5; i++) send_byte(frame1[i]);
        reset = 1'b1;
        #2;
        chk("t6_rst_wren",  64'(Wr_En), 64'd0);
        chk("t6_rst_waddr", Wr_Address, 64'd0);
        chk("t6_rst_hold",  64'(Cpu_Hold), 64'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        bubbles(1);
        base = wr_cnt;
        for (int i = 0; i < 8; i++) send_byte(frame1[i]);
        bubbles(1);
        chk_writes("t6", base);
        chk("t6_done",  64'(Done), 64'd1);
        chk("t6_error", 64'(Error), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
